// File: rtl/debounce_fsm.sv
// Switch debouncer: two-flop synchronizer, free-running sample-tick divider,
// and a four-state hold FSM that accepts a new level only after it has been
// stable for STABLE_TICKS consecutive sample ticks.
module debounce_fsm #(
  parameter int N            = 20,
  parameter int STABLE_TICKS = 3
) (
  input  logic CLK,
  input  logic reset,
  input  logic sw,
  output logic db_level,
  output logic db_tick
);

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_t;

  // Hold counter reload value: the final tick is the one seen with cnt == 0.
  localparam logic [3:0] LOAD = 4'(STABLE_TICKS - 1);

  logic         s1_q;
  logic         sw_s_q;
  logic [N-1:0] tick_q;
  logic [N-1:0] tick_d;
  logic         m_tick;
  state_t       state_q;
  logic [3:0]   cnt_q;

  assign tick_d = tick_q + 1'b1;
  assign m_tick = &tick_q;

  // Two-flop synchronizer bringing the raw switch into the CLK domain.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b0;
      sw_s_q <= 1'b0;
    end else begin
      s1_q   <= sw;
      sw_s_q <= s1_q;
    end
  end

  // Sample-tick divider: free-running in every state, cleared only by reset.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

  // Hold FSM: a return to the current level always beats a pending tick.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= ZERO;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        ZERO: begin
          if (sw_s_q) begin
            state_q <= WAIT1;
            cnt_q   <= LOAD;
          end
        end
        WAIT1: begin
          if (!sw_s_q) begin
            state_q <= ZERO;
          end else if (m_tick) begin
            if (cnt_q == 4'd0) begin
              state_q <= ONE;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        ONE: begin
          if (!sw_s_q) begin
            state_q <= WAIT0;
            cnt_q   <= LOAD;
          end
        end
        WAIT0: begin
          if (sw_s_q) begin
            state_q <= ONE;
          end else if (m_tick) begin
            if (cnt_q == 4'd0) begin
              state_q <= ZERO;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        default: begin
          state_q <= ZERO;
        end
      endcase
    end
  end

  // Level follows the accepted state; the press pulse fires in the accepting cycle.
  assign db_level = (state_q == ONE) || (state_q == WAIT0);
  assign db_tick  = (state_q == WAIT1) && sw_s_q && m_tick && (cnt_q == 4'd0);

endmodule

// File: tb/tb_debounce_fsm.sv
// Randomized and table-driven bench for debounce_fsm (N=3, STABLE_TICKS=3).
// The reference model tracks the accepted level and the edge index at which
// the synchronized input started to disagree with it; a change is accepted
// on the STABLE_TICKS-th sample tick after that edge, counted arithmetically.
module tb_debounce_fsm;

  localparam int N      = 3;
  localparam int STABLE = 3;
  localparam int PERIOD = 1 << N;

  logic clk;
  logic reset;
  logic sw;
  logic db_level;
  logic db_tick;

  int n_vec;
  int n_err;

  // model state
  int   j;          // edge index since reset release (first edge = 0)
  logic h0, h1;     // sw sampled at edge j-1 and j-2
  logic lvl;        // accepted level
  int   run_start;  // edge where disagreement began, -1 if none

  debounce_fsm #(.N(N), .STABLE_TICKS(STABLE)) dut (
    .CLK      (clk),
    .reset    (reset),
    .sw       (sw),
    .db_level (db_level),
    .db_tick  (db_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t edge=%0d: got %b expected %b", tag, $time, j, got, exp);
    end
  endtask

  // number of sample ticks at edges in (s, e]; ticks occur at edges k with k%PERIOD==PERIOD-1
  function automatic int ticks_between(input int s, input int e);
    return (e + 1) / PERIOD - (s + 1) / PERIOD;
  endfunction

  function automatic logic accept_now();
    logic sws;
    sws = h1;
    return (run_start >= 0) && (sws != lvl) && ((j % PERIOD) == PERIOD - 1) &&
           (ticks_between(run_start, j) == STABLE);
  endfunction

  task automatic model_reset();
    j = 0; h0 = 1'b0; h1 = 1'b0; lvl = 1'b0; run_start = -1;
  endtask

  // Called just after a negedge: check outputs, drive sw, advance one edge.
  task automatic step(input logic v);
    logic sws, acc;
    sws = h1;
    acc = accept_now();
    check_eq("db_tick", db_tick, acc && sws);
    check_eq("db_level", db_level, lvl);
    sw = v;
    @(posedge clk);
    if (run_start < 0) begin
      if (sws != lvl) run_start = j;
    end else if (sws == lvl) begin
      run_start = -1;
    end else if (acc) begin
      lvl = sws;
      run_start = -1;
    end
    h1 = h0;
    h0 = v;
    j++;
    @(negedge clk);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic pulse_reset(input int hold_edges);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_level", db_level, 1'b0);
    check_eq("rst_tick", db_tick, 1'b0);
    for (int k = 0; k < hold_edges; k++) @(posedge clk);
    @(negedge clk);
    check_eq("rst_hold_level", db_level, 1'b0);
    reset = 1'b0;
    model_reset();
  endtask

  // directed segments: value (2 = async reset), length in clocks
  int seg_v [21] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 2, 1};
  int seg_n [21] = '{100, 17, 12, 40, 6, 10, 40, 5, 5, 5, 5, 5, 5, 5, 5, 40, 40, 15, 40, 3, 40};

  initial begin
    n_vec = 0;
    n_err = 0;
    sw    = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    check_eq("init_level", db_level, 1'b0);
    check_eq("init_tick", db_tick, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int s = 0; s < 21; s++) begin
      if (seg_v[s] == 2) begin
        pulse_reset(seg_n[s]);
      end else begin
        for (int k = 0; k < seg_n[s]; k++) step(seg_v[s][0]);
      end
    end

    for (int s = 0; s < 60; s++) begin
      int   len;
      logic v;
      if ($urandom_range(0, 11) == 0) begin
        pulse_reset(int'($urandom_range(1, 3)));
      end
      v   = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(20, 40)) : int'($urandom_range(1, 12));
      for (int k = 0; k < len; k++) step(v);
    end

    for (int k = 0; k < 40; k++) step(sw);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/debounce_fsm.md
Name: debounce_fsm

Overview:
- Conditions a raw mechanical switch or button input before it reaches the edge detector.
- Synchronizes the asynchronous input to CLK.
- Rejects bounce by requiring the input to hold a new value for a programmable number of sample ticks.
- Outputs a clean level (db_level), which feeds the downstream edge detector's level input, plus a one-cycle press pulse.

Parameters:
- N, 20: width of the free-running sample-tick counter; one sample tick every 2^N clocks.
- STABLE_TICKS, 3: consecutive sample ticks the synchronized input must hold before a change is accepted; legal range 1..15.

Ports:
- CLK  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- sw  input  1  raw switch input, asynchronous to CLK, may bounce.
- db_level  output  1  debounced level; feeds the edge detector.
- db_tick  output  1  one-CLK pulse when a 0->1 change is accepted.

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - both synchronizer flops, the tick counter and the hold counter are 0;
  - state is ZERO;
  - db_level=0 and db_tick=0, immediately and without waiting for a clock edge.
- Synchronizer: two flops in series, sw -> s1 -> sw_s. sw_s lags sw by 2 clocks.
- Tick counter:
  - N-bit, increments every clock and wraps from 2^N-1 to 0.
  - m_tick=1 in the cycle the counter equals 2^N-1.
  - After reset release, the first m_tick is on clock 2^N-1, counting the first edge as clock 0.
- Hold counter cnt:
  - 4 bits, loaded with STABLE_TICKS-1 on entry to WAIT1 or WAIT0.
  - Decrements only on m_tick while waiting.
- State machine (all transitions on the CLK rising edge):
  - ZERO:
    - sw_s=1 -> WAIT1, load cnt.
  - WAIT1:
    - sw_s=0 -> ZERO. The bounce is rejected and this takes priority over m_tick.
    - Else if m_tick and cnt=0 -> ONE, and db_tick=1 in this cycle.
    - Else if m_tick -> cnt-1.
  - ONE:
    - sw_s=0 -> WAIT0, load cnt.
  - WAIT0:
    - sw_s=1 -> ONE. Rejected, with priority as in WAIT1. No db_tick is produced.
    - Else if m_tick and cnt=0 -> ZERO.
    - Else if m_tick -> cnt-1.
  - Unreachable state encodings -> ZERO.
- Outputs:
  - db_level is decoded from the state: 1 in ONE and WAIT0, 0 in ZERO and WAIT1.
  - db_level rises on the clock after the db_tick cycle.
  - db_tick is Mealy (combinational from state, sw_s, m_tick and cnt) and lasts exactly one cycle per accepted press.
  - No pulse is produced on release.
- Acceptance latency, measured from sw_s changing to db_level changing: between (STABLE_TICKS-1)*2^N+2 and STABLE_TICKS*2^N+1 clocks.
  - The exact value depends on the tick counter's phase.
  - With STABLE_TICKS=1, the change is accepted at the first m_tick after entering the wait state.
- Edge case: if the input returns in the same cycle as the final m_tick, the return wins and the change is rejected.
- The tick counter free-runs in every state and is never cleared except by reset.
- Reset mid-wait abandons the pending change. After release the block restarts from ZERO with db_level=0, even if sw is held high.

Test Plan (N=3, STABLE_TICKS=3; m_tick every 8 clocks):
- Reset release with sw=0 held for 100 clocks -> db_level=0 and db_tick=0 throughout; m_tick observed at clocks 7, 15, 23.
- Clean press: sw 0->1 held -> exactly one db_tick pulse, 19..27 clocks after the sw change. db_level=1 on the following cycle and stays 1.
- Bounce on press: sw toggles 1/0 every 5 clocks for 40 clocks, then settles at 1 -> no db_tick and db_level=0 during bouncing. A single db_tick follows within 27 clocks after settling.
- Release with bounce: from db_level=1, sw drops to 0 for 6 clocks, returns to 1, then drops to 0 permanently -> db_level stays 1 through the glitch and falls 19..27 clocks after the final drop. No db_tick occurs at any point.
- Reset mid-operation: assert reset while in WAIT1 with cnt=1 -> state ZERO, db_level=0 and no db_tick, asynchronously. After release with sw=1 held, a full 19..27-clock acceptance occurs again.
- Simultaneous event: sw_s returns to 0 in the same cycle as the final m_tick in WAIT1 -> state goes to ZERO, db_tick=0, db_level stays 0.
